// File: rtl/memory_access_unit.sv
// MEM-stage data memory with configurable width, depth and read latency; reads stall the pipeline.
// Byte loads/stores (lane merge, sign/zero extension) are built only when MEMORY_ACCESS_UNIT_BYTE_EN is defined.
module memory_access_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Sig_MemRead,
  input  logic                  i_Sig_MemWrite,
  input  logic                  i_Byte_Access,
  input  logic                  i_Sign_Extend,
  input  logic [ADDR_WIDTH-1:0] i_Address,
  input  logic [DATA_WIDTH-1:0] i_Write_Data,
  output logic [DATA_WIDTH-1:0] o_Read_Data,
  output logic                  o_Read_Valid,
  output logic                  o_Stall,
  output logic                  o_Misaligned
);
  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mis_q, mis_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  logic [LANE_BITS-1:0]  lane;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_BITS-1:0]   idx;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  byte_acc;
  logic                  aligned;
  logic                  accept;
  logic                  mem_we;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] fmt_data;

  assign lane      = i_Address[LANE_BITS-1:0];
  assign word_addr = i_Address >> LANE_BITS;
  // Out-of-range word indices alias back into the array.
  assign idx       = IDX_BITS'(word_addr % ADDR_WIDTH'(DEPTH));

`ifdef MEMORY_ACCESS_UNIT_BYTE_EN
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic                 sext_q, sext_d;
  logic                 byte_q, byte_d;
  logic [7:0]           rd_byte;

  assign byte_acc = i_Byte_Access;

  always_comb begin
    wr_word = i_Write_Data;
    lane_we = '1;
    if (byte_acc) begin
      wr_word = {LANES{i_Write_Data[7:0]}};
      lane_we = LANES'(1) << lane;
    end
  end

  always_comb begin
    lane_d = lane_q;
    sext_d = sext_q;
    byte_d = byte_q;
    if (accept) begin
      lane_d = lane;
      sext_d = i_Sign_Extend;
      byte_d = i_Byte_Access;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      sext_q <= 1'b0;
      byte_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      sext_q <= sext_d;
      byte_q <= byte_d;
    end
  end

  assign rd_byte  = mem_rd_q[8*int'(lane_q) +: 8];
  assign fmt_data = byte_q ? {{(DATA_WIDTH-8){sext_q & rd_byte[7]}}, rd_byte} : mem_rd_q;
`else
  logic unused_byte_ctl;
  assign unused_byte_ctl = i_Byte_Access ^ i_Sign_Extend;
  assign byte_acc = 1'b0;
  assign wr_word  = i_Write_Data;
  assign lane_we  = '1;
  assign fmt_data = mem_rd_q;
`endif

  assign aligned = byte_acc | (lane == '0);
  assign accept  = (state_q == S_IDLE) & i_Sig_MemRead & ~i_Sig_MemWrite & aligned;
  assign mem_we  = ~rst & (state_q == S_IDLE) & i_Sig_MemWrite & aligned;
  // The RAM is addressed straight from the request in the accept cycle so the data is ready one cycle later.
  assign rd_idx  = (state_q == S_IDLE) ? idx : idx_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && lane_we[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
    mem_rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    mis_d   = (state_q == S_IDLE) & (i_Sig_MemRead | i_Sig_MemWrite) & ~aligned;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = 3'(READ_LATENCY - 1);
          idx_d   = idx;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = fmt_data;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Stall      = 1'b0;
    o_Read_Valid = 1'b0;
    if (!rst) begin
      o_Stall      = accept | (state_q == S_WAIT);
      o_Read_Valid = (state_q == S_DONE);
    end
  end

  assign o_Read_Data  = rdata_q;
  assign o_Misaligned = mis_q;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Parametrised data-memory access unit for the MEM stage of the pipelined MIPS core. It replaces the fixed 16-bit, single-cycle data-memory stage with configurable data width, depth and read latency. It adds byte stores and loads with sign or zero extension, misalignment detection, and a stall output that freezes the pipeline while a multi-cycle read is outstanding. Writes complete in one cycle; reads are tracked by a small FSM with a wait-state counter.

## Interface
Parameters:
- DATA_WIDTH, 16: word width in bits; multiple of 8, at least 16.
- ADDR_WIDTH, 16: byte-address width.
- DEPTH, 256: number of memory words.
- READ_LATENCY, 1: read wait states; legal range 1–8.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- i_Sig_MemRead  input  1  read request; held stable while o_Stall=1.
- i_Sig_MemWrite  input  1  write request.
- i_Byte_Access  input  1  1 = byte access, 0 = full-word access.
- i_Sign_Extend  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- i_Address  input  ADDR_WIDTH  byte address.
- i_Write_Data  input  DATA_WIDTH  store data; byte stores use bits [7:0].
- o_Read_Data  output  DATA_WIDTH  registered load result.
- o_Read_Valid  output  1  one-cycle pulse when o_Read_Data updates.
- o_Stall  output  1  pipeline freeze request.
- o_Misaligned  output  1  one-cycle registered pulse on a misaligned word access.

## Operation
- Address decoding:
  - LANE_BITS = log2(DATA_WIDTH/8).
  - lane = i_Address[LANE_BITS-1:0].
  - word index = i_Address[ADDR_WIDTH-1:LANE_BITS] mod DEPTH. Out-of-range addresses wrap.
- Misalignment: a word access with lane≠0 is misaligned.
  - It has no memory effect, no stall and no o_Read_Valid.
  - o_Misaligned=1 for the next cycle.
  - Byte accesses are never misaligned.
- Writes are accepted only in IDLE.
  - They commit at the clock edge with no stall.
  - A byte store updates only byte lane `lane`; other lanes are unchanged.
- Read-while-write: if i_Sig_MemRead and i_Sig_MemWrite are both 1, the write is performed and the read is ignored.
- Read FSM:
  - IDLE: a read that is aligned and has no write → WAIT. The unit latches the address and controls and loads cnt=READ_LATENCY-1.
  - WAIT: while cnt≠0, decrement cnt. When cnt=0, capture memory data and format it → DONE.
  - DONE: o_Read_Valid=1 and o_Stall=0. Inputs are ignored, because the requester still presents the completed read. Always → IDLE.
- Load formatting:
  - Word read: data is returned unchanged.
  - Byte read: the selected lane is placed in [7:0]. Upper bits are filled with bit 7 if i_Sign_Extend=1, otherwise zeros.
- o_Read_Data holds its value until the next completed read.
- Read data reflects all writes committed before the WAIT→DONE edge.

## Timing
- o_Stall = (IDLE & read accepted) | WAIT. It is combinational so the pipeline freezes in the acceptance cycle.
- Read: accepted in cycle 0; o_Stall high in cycles 0..READ_LATENCY; o_Read_Valid and new o_Read_Data in cycle READ_LATENCY+1.
- A new request can be accepted no earlier than cycle READ_LATENCY+2, back in IDLE.
- Write: zero stall cycles; one write per cycle in IDLE.
- Reset values:
  - FSM = IDLE, cnt = 0.
  - o_Read_Data = 0, o_Read_Valid = 0, o_Stall = 0 (while rst is high), o_Misaligned = 0.
  - Memory contents are not reset.
- Reset during WAIT or DONE aborts the read: no o_Read_Valid pulse, o_Read_Data = 0, FSM = IDLE.

## Configuration
- MEMORY_ACCESS_UNIT_BYTE_EN defined: byte loads and stores behave as described above.
- Undefined: i_Byte_Access and i_Sign_Extend are ignored.
  - Every access is a full-word access.
  - Misalignment checking still applies.
  - The lane-merge and extension logic is not built.

## Test plan
Bench configuration: DATA_WIDTH=16, READ_LATENCY=2.
- Word write 0xBEEF @0x0010, then read @0x0010 → o_Stall high for exactly 3 cycles; o_Read_Valid in cycle 3; o_Read_Data=0xBEEF.
- Byte store 0x80 @0x0011 over word 0x1234 → word becomes 0x8034. Signed byte load @0x0011 → 0xFF80. Unsigned byte load → 0x0080.
- Word read @0x0013 → o_Misaligned pulses once; o_Stall=0; no o_Read_Valid; memory unchanged.
- Read and write both asserted @0x0020 with data 0x5A5A → write performed, no stall. A following read returns 0x5A5A.
- rst asserted in WAIT → next cycle FSM in IDLE, o_Stall=0, o_Read_Data=0, no o_Read_Valid pulse.
- Address 0x0200 with DEPTH=256 → aliases word 0. A write there is readable at 0x0000.
